decode_alu_unit: RTL and testbench

- Front half of an MCCP core's datapath: a registered instruction decoder plus a registered 32-bit ALU.
- Decoder selects one 16-bit half or a whole 32-bit long word, evaluates the condition suffix against core flags, and emits control strobes/fields.
- ALU computes on operand values the core fetches using the decoded register codes.

---
 rtl/mccp_pkg.sv | 76 +++++++
 rtl/decode_alu_unit_alu.sv | 105 ++++++++++
 rtl/decode_alu_unit.sv | 213 +++++++++++++++++++++
 tb/tb_decode_alu_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mccp_pkg.sv
// rtl/mccp_pkg.sv - shared constants for the MCCP decode/ALU front end
// Purpose: flag bit indices, ALU opcodes, instruction class, mov type,
//          SYS sub-codes and condition codes, plus the suffix evaluator.
// Ports:   none (package).
package mccp_pkg;

  localparam int FLAG_CF = 0;
  localparam int FLAG_SF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_ZF = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADC  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SBB  = 4'd3,
    ALU_MUL  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOT  = 4'd8,
    ALU_SHL  = 4'd9,
    ALU_SHR  = 4'd10,
    ALU_SAR  = 4'd11,
    ALU_INC  = 4'd12,
    ALU_DEC  = 4'd13,
    ALU_CMP  = 4'd14,
    ALU_PASS = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_MOV = 2'b01,
    CLS_MEM = 2'b10,
    CLS_SYS = 2'b11
  } instr_class_e;

  localparam logic [2:0] MOV_REG  = 3'b000;
  localparam logic [2:0] MOV_L    = 3'b001;
  localparam logic [2:0] MOV_H    = 3'b010;
  localparam logic [2:0] MOV_F    = 3'b011;
  localparam logic [2:0] MOV_JUMP = 3'b111;

  localparam logic [1:0] SYS_INT   = 2'b00;
  localparam logic [1:0] SYS_STACK = 2'b01;

  typedef enum logic [2:0] {
    COND_AL    = 3'd0,
    COND_Z     = 3'd1,
    COND_NZ    = 3'd2,
    COND_LT    = 3'd3,
    COND_GE    = 3'd4,
    COND_C     = 3'd5,
    COND_NC    = 3'd6,
    COND_CORE0 = 3'd7
  } cond_e;

  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] fl,
                                    input logic core0);
    logic ok;
    ok = 1'b0;
    case (cond_e'(cond))
      COND_AL:    ok = 1'b1;
      COND_Z:     ok = fl[FLAG_ZF];
      COND_NZ:    ok = !fl[FLAG_ZF];
      COND_LT:    ok = fl[FLAG_SF] != fl[FLAG_OF];
      COND_GE:    ok = fl[FLAG_SF] == fl[FLAG_OF];
      COND_C:     ok = fl[FLAG_CF];
      COND_NC:    ok = !fl[FLAG_CF];
      COND_CORE0: ok = core0;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_alu_unit_alu.sv
// rtl/decode_alu_unit_alu.sv - registered 32-bit ALU (module alu_unit)
// Purpose: computes result and CF/SF/OF/ZF for the decoded opcode and latches
//          them, with the destination register code, when en is high.
// Ports:   clk, rst (async, active high); en; opcode; op1_code; a, b operand
//          values; cin; result, result_flags, dest_out registered outputs.
module alu_unit
  import mccp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FLAGS       = 4,
  parameter int OPCODE      = 4,
  parameter int REGS_CODING = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [OPCODE-1:0]      opcode,
  input  logic [REGS_CODING-1:0] op1_code,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  output logic [WIDTH-1:0]       result,
  output logic [FLAGS-1:0]       result_flags,
  output logic [REGS_CODING-1:0] dest_out
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]       result_d, result_q;
  logic [FLAGS-1:0]       flags_d, flags_q;
  logic [REGS_CODING-1:0] dest_d, dest_q;

  logic             arith, sub_op, carry;
  logic [WIDTH-1:0] bx, res;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   sh;

  // All add/subtract flavours share one adder: inc/dec reuse it with b=1,
  // and cmp keeps op1 as the result while flags come from the difference.
  always_comb begin
    arith  = 1'b0;
    sub_op = 1'b0;
    carry  = 1'b0;
    bx     = b;
    res    = '0;
    sh     = b[SHW-1:0];
    case (alu_op_e'(opcode))
      ALU_ADD:  arith = 1'b1;
      ALU_ADC:  begin arith = 1'b1; carry = cin; end
      ALU_SUB:  begin arith = 1'b1; sub_op = 1'b1; end
      ALU_SBB:  begin arith = 1'b1; sub_op = 1'b1; carry = cin; end
      ALU_INC:  begin arith = 1'b1; bx = {{(WIDTH-1){1'b0}}, 1'b1}; end
      ALU_DEC:  begin arith = 1'b1; sub_op = 1'b1; bx = {{(WIDTH-1){1'b0}}, 1'b1}; end
      ALU_CMP:  begin arith = 1'b1; sub_op = 1'b1; end
      ALU_MUL:  res = a * b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOT:  res = ~a;
      ALU_SHL:  res = a << sh;
      ALU_SHR:  res = a >> sh;
      ALU_SAR:  res = WIDTH'($signed(a) >>> sh);
      ALU_PASS: res = b;
      default:  res = '0;
    endcase

    // Bit WIDTH is carry out for additions and borrow for subtractions.
    if (sub_op) wide = {1'b0, a} - {1'b0, bx} - {{WIDTH{1'b0}}, carry};
    else        wide = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, carry};

    flags_d = '0;
    if (arith) begin
      res               = (alu_op_e'(opcode) == ALU_CMP) ? a : wide[WIDTH-1:0];
      flags_d[FLAG_CF]  = wide[WIDTH];
      flags_d[FLAG_OF]  = sub_op ? ((a[WIDTH-1] != bx[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]))
                                 : ((a[WIDTH-1] == bx[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]));
      flags_d[FLAG_SF]  = wide[WIDTH-1];
      flags_d[FLAG_ZF]  = (wide[WIDTH-1:0] == '0);
    end else begin
      flags_d[FLAG_SF]  = res[WIDTH-1];
      flags_d[FLAG_ZF]  = (res == '0);
    end

    result_d = en ? res : result_q;
    dest_d   = en ? op1_code : dest_q;
    if (!en) flags_d = flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      dest_q   <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      dest_q   <= dest_d;
    end
  end

  assign result       = result_q;
  assign result_flags = flags_q;
  assign dest_out     = dest_q;

endmodule

// File: rtl/decode_alu_unit.sv
// rtl/decode_alu_unit.sv - registered MCCP instruction decoder plus ALU
// Purpose: decodes a long word or one 16-bit half on dec_en, evaluates the
//          condition suffix against flags, and drives the ALU sub-module.
// Ports:   clk, rst; dec_en, long_instr, instr_choose, flags, core_index in;
//          decoded strobes and fields out; alu_go, op1_data, op2_data, cin in;
//          result, result_flags, dest_out out.
module decode_alu_unit
  import mccp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int REGS_CODING = 3,
  parameter int FLAGS       = 4,
  parameter int OPCODE      = 4,
  parameter int MOV_CODE    = 3,
  parameter int CORE_NUM    = 2,
  parameter int INT_NUM     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_en,
  input  logic [WIDTH-1:0]       long_instr,
  input  logic                   instr_choose,
  input  logic [FLAGS-1:0]       flags,
  input  logic [CORE_NUM-1:0]    core_index,
  output logic                   alu_en,
  output logic                   mem_en,
  output logic                   wren,
  output logic                   move_en,
  output logic                   interrupt,
  output logic                   write_stack_params,
  output logic                   suffix,
  output logic [OPCODE-1:0]      alu_opcode,
  output logic [MOV_CODE-1:0]    mov_type,
  output logic [WIDTH/2-1:0]     immediate,
  output logic [REGS_CODING-1:0] op1,
  output logic [REGS_CODING-1:0] op2,
  output logic [INT_NUM-1:0]     int_num,
  output logic [1:0]             stack_param_coding,
  output logic [REGS_CODING-1:0] stack_param_reg,
  input  logic                   alu_go,
  input  logic [WIDTH-1:0]       op1_data,
  input  logic [WIDTH-1:0]       op2_data,
  input  logic                   cin,
  output logic [WIDTH-1:0]       result,
  output logic [FLAGS-1:0]       result_flags,
  output logic [REGS_CODING-1:0] dest_out
);

  logic alu_en_d, alu_en_q, mem_en_d, mem_en_q, wren_d, wren_q;
  logic move_en_d, move_en_q, interrupt_d, interrupt_q;
  logic wsp_d, wsp_q, suffix_d, suffix_q;
  logic [OPCODE-1:0]      alu_opcode_d, alu_opcode_q;
  logic [MOV_CODE-1:0]    mov_type_d, mov_type_q;
  logic [WIDTH/2-1:0]     immediate_d, immediate_q;
  logic [REGS_CODING-1:0] op1_d, op1_q, op2_d, op2_q, spr_d, spr_q;
  logic [INT_NUM-1:0]     int_num_d, int_num_q;
  logic [1:0]             spc_d, spc_q;

  logic [15:0] h;
  logic [2:0]  cond;

  always_comb begin
    h    = instr_choose ? long_instr[15:0] : long_instr[31:16];
    cond = h[14:12];

    alu_en_d     = alu_en_q;
    mem_en_d     = mem_en_q;
    wren_d       = wren_q;
    move_en_d    = move_en_q;
    interrupt_d  = interrupt_q;
    wsp_d        = wsp_q;
    suffix_d     = suffix_q;
    alu_opcode_d = alu_opcode_q;
    mov_type_d   = mov_type_q;
    immediate_d  = immediate_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    int_num_d    = int_num_q;
    spc_d        = spc_q;
    spr_d        = spr_q;

    if (dec_en) begin
      // Every field not owned by the decoded class reads back as zero.
      alu_en_d     = 1'b0;
      mem_en_d     = 1'b0;
      wren_d       = 1'b0;
      move_en_d    = 1'b0;
      interrupt_d  = 1'b0;
      wsp_d        = 1'b0;
      alu_opcode_d = '0;
      mov_type_d   = '0;
      immediate_d  = '0;
      op1_d        = '0;
      op2_d        = '0;
      int_num_d    = '0;
      spc_d        = '0;
      spr_d        = '0;

      // Bit 31 marks a long movl/movh no matter which half was selected.
      if (long_instr[31]) begin
        cond        = long_instr[30:28];
        move_en_d   = 1'b1;
        mov_type_d  = long_instr[27] ? MOV_H : MOV_L;
        op1_d       = long_instr[26:24];
        immediate_d = long_instr[15:0];
      end else if (!h[15]) begin
        case (instr_class_e'(h[11:10]))
          CLS_ALU: begin
            alu_en_d     = 1'b1;
            alu_opcode_d = h[9:6];
            op1_d        = h[5:3];
            op2_d        = h[2:0];
          end
          CLS_MOV: begin
            move_en_d  = 1'b1;
            mov_type_d = h[9:7];
            op1_d      = h[5:3];
            op2_d      = h[2:0];
          end
          CLS_MEM: begin
            mem_en_d = 1'b1;
            wren_d   = h[9];
            op1_d    = h[5:3];
            op2_d    = h[2:0];
          end
          CLS_SYS: begin
            if (h[9:8] == SYS_INT) begin
              interrupt_d = 1'b1;
              int_num_d   = h[2:0];
            end else if (h[9:8] == SYS_STACK) begin
              wsp_d = 1'b1;
              spc_d = h[7:6];
              spr_d = h[2:0];
            end
          end
          default: ;
        endcase
      end

      suffix_d = cond_met(cond, flags, core_index == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_en_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      wren_q       <= 1'b0;
      move_en_q    <= 1'b0;
      interrupt_q  <= 1'b0;
      wsp_q        <= 1'b0;
      suffix_q     <= 1'b0;
      alu_opcode_q <= '0;
      mov_type_q   <= '0;
      immediate_q  <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      int_num_q    <= '0;
      spc_q        <= '0;
      spr_q        <= '0;
    end else begin
      alu_en_q     <= alu_en_d;
      mem_en_q     <= mem_en_d;
      wren_q       <= wren_d;
      move_en_q    <= move_en_d;
      interrupt_q  <= interrupt_d;
      wsp_q        <= wsp_d;
      suffix_q     <= suffix_d;
      alu_opcode_q <= alu_opcode_d;
      mov_type_q   <= mov_type_d;
      immediate_q  <= immediate_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      int_num_q    <= int_num_d;
      spc_q        <= spc_d;
      spr_q        <= spr_d;
    end
  end

  assign alu_en             = alu_en_q;
  assign mem_en             = mem_en_q;
  assign wren               = wren_q;
  assign move_en            = move_en_q;
  assign interrupt          = interrupt_q;
  assign write_stack_params = wsp_q;
  assign suffix             = suffix_q;
  assign alu_opcode         = alu_opcode_q;
  assign mov_type           = mov_type_q;
  assign immediate          = immediate_q;
  assign op1                = op1_q;
  assign op2                = op2_q;
  assign int_num            = int_num_q;
  assign stack_param_coding = spc_q;
  assign stack_param_reg    = spr_q;

  // The ALU executes against the decode currently held in the registers.
  alu_unit #(
    .WIDTH(WIDTH), .FLAGS(FLAGS), .OPCODE(OPCODE), .REGS_CODING(REGS_CODING)
  ) u_alu (
    .clk          (clk),
    .rst          (rst),
    .en           (alu_go && alu_en_q),
    .opcode       (alu_opcode_q),
    .op1_code     (op1_q),
    .a            (op1_data),
    .b            (op2_data),
    .cin          (cin),
    .result       (result),
    .result_flags (result_flags),
    .dest_out     (dest_out)
  );

endmodule

// File: tb/tb_decode_alu_unit.sv
// tb/tb_decode_alu_unit.sv - self-checking bench for decode_alu_unit
module tb_decode_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_en, instr_choose, alu_go, cin;
  logic [31:0] long_instr, op1_data, op2_data;
  logic [3:0]  flags;
  logic [1:0]  core_index;
  logic        alu_en, mem_en, wren, move_en, interrupt, write_stack_params, suffix;
  logic [3:0]  alu_opcode;
  logic [2:0]  mov_type, op1, op2, int_num, stack_param_reg, dest_out;
  logic [15:0] immediate;
  logic [1:0]  stack_param_coding;
  logic [31:0] result;
  logic [3:0]  result_flags;

  always #5 clk = ~clk;

  decode_alu_unit dut (
    .clk(clk), .rst(rst), .dec_en(dec_en), .long_instr(long_instr),
    .instr_choose(instr_choose), .flags(flags), .core_index(core_index),
    .alu_en(alu_en), .mem_en(mem_en), .wren(wren), .move_en(move_en),
    .interrupt(interrupt), .write_stack_params(write_stack_params), .suffix(suffix),
    .alu_opcode(alu_opcode), .mov_type(mov_type), .immediate(immediate),
    .op1(op1), .op2(op2), .int_num(int_num), .stack_param_coding(stack_param_coding),
    .stack_param_reg(stack_param_reg), .alu_go(alu_go), .op1_data(op1_data),
    .op2_data(op2_data), .cin(cin), .result(result), .result_flags(result_flags),
    .dest_out(dest_out)
  );

  typedef struct packed {
    logic        alu_en, mem_en, wren, move_en, interrupt, wsp, suffix;
    logic [3:0]  opc;
    logic [2:0]  mt;
    logic [15:0] imm;
    logic [2:0]  op1, op2, intn;
    logic [1:0]  spc;
    logic [2:0]  spr;
  } dec_t;

  dec_t dut_dec;
  assign dut_dec = {alu_en, mem_en, wren, move_en, interrupt, write_stack_params, suffix,
                    alu_opcode, mov_type, immediate, op1, op2, int_num,
                    stack_param_coding, stack_param_reg};

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decoder: fields straight from the instruction-format table.
  function automatic dec_t model_dec(logic [31:0] li, logic ch, logic [3:0] fl, logic [1:0] ci);
    dec_t d;
    logic [15:0] hw;
    logic [2:0] c;
    logic zf, sf, of, cf;
    d  = '0;
    hw = ch ? li[15:0] : li[31:16];
    c  = hw[14:12];
    if (li[31]) begin
      c = li[30:28]; d.move_en = 1; d.mt = li[27] ? 3'b010 : 3'b001;
      d.op1 = li[26:24]; d.imm = li[15:0];
    end else if (hw[15] == 1'b0) begin
      if (hw[11:10] == 0) begin d.alu_en = 1; d.opc = hw[9:6]; d.op1 = hw[5:3]; d.op2 = hw[2:0]; end
      if (hw[11:10] == 1) begin d.move_en = 1; d.mt = hw[9:7]; d.op1 = hw[5:3]; d.op2 = hw[2:0]; end
      if (hw[11:10] == 2) begin d.mem_en = 1; d.wren = hw[9]; d.op1 = hw[5:3]; d.op2 = hw[2:0]; end
      if (hw[11:10] == 3 && hw[9:8] == 0) begin d.interrupt = 1; d.intn = hw[2:0]; end
      if (hw[11:10] == 3 && hw[9:8] == 1) begin d.wsp = 1; d.spc = hw[7:6]; d.spr = hw[2:0]; end
    end
    cf = fl[0]; sf = fl[1]; of = fl[2]; zf = fl[3];
    d.suffix = (c == 0) || (c == 1 && zf) || (c == 2 && !zf) || (c == 3 && sf != of) ||
               (c == 4 && sf == of) || (c == 5 && cf) || (c == 6 && !cf) || (c == 7 && ci == 0);
    return d;
  endfunction

  // Reference ALU using wide integer arithmetic; returns {flags, result}.
  function automatic logic [35:0] model_alu(logic [3:0] opc, logic [31:0] a, logic [31:0] b0, logic c);
    longint u, s;
    logic [31:0] r, b;
    logic cf, of, arith;
    b = b0; arith = 1; cf = 0; of = 0; r = 0; u = 0; s = 0;
    if (opc == 12 || opc == 13) b = 32'd1;
    case (opc)
      0, 1, 12: begin
        u = longint'(a) + longint'(b) + ((opc == 1) ? longint'(c) : 0);
        s = longint'($signed(a)) + longint'($signed(b)) + ((opc == 1) ? longint'(c) : 0);
      end
      2, 3, 13, 14: begin
        u = longint'(a) - longint'(b) - ((opc == 3) ? longint'(c) : 0);
        s = longint'($signed(a)) - longint'($signed(b)) - ((opc == 3) ? longint'(c) : 0);
      end
      default: arith = 0;
    endcase
    case (opc)
      4:  begin u = longint'(a) * longint'(b); r = u[31:0]; end
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = ~a;
      9:  r = a << b[4:0];
      10: r = a >> b[4:0];
      11: r = 32'($signed(a) >>> b[4:0]);
      15: r = b;
      default: r = u[31:0];
    endcase
    if (arith) begin
      cf = ((u >>> 32) != 0);
      of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    // cmp reports op1 but flags reflect the difference held in r here
    return {(r == 0), of, r[31], cf, (opc == 14) ? a : r};
  endfunction

  dec_t        e_dec  = '0;
  logic [31:0] e_res  = '0;
  logic [3:0]  e_fl   = '0;
  logic [2:0]  e_dest = '0;

  always @(posedge clk or posedge rst) begin
    logic [35:0] m;
    if (rst) begin
      e_dec = '0; e_res = '0; e_fl = '0; e_dest = '0;
    end else begin
      if (alu_go && e_dec.alu_en) begin
        m = model_alu(e_dec.opc, op1_data, op2_data, cin);
        e_res = m[31:0]; e_fl = m[35:32]; e_dest = e_dec.op1;
      end
      if (dec_en) e_dec = model_dec(long_instr, instr_choose, flags, core_index);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("decode_fields", dut_dec, e_dec);
      chk("alu_result", result, e_res);
      chk("alu_flags", result_flags, e_fl);
      chk("alu_dest", dest_out, e_dest);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_dec(input logic [31:0] li, input logic ch, input logic [3:0] fl, input logic [1:0] ci);
    long_instr = li; instr_choose = ch; flags = fl; core_index = ci;
    dec_en = 1; alu_go = 0;
    step();
    dec_en = 0;
  endtask

  task automatic do_alu(input logic [31:0] a, input logic [31:0] b, input logic c);
    op1_data = a; op2_data = b; cin = c; alu_go = 1;
    step();
    alu_go = 0;
  endtask

  function automatic logic [31:0] mk_alu(logic [3:0] opc, logic [2:0] d, logic [2:0] s);
    logic [15:0] hw;
    hw = {1'b0, 3'b000, 2'b00, opc, d, s};
    return {hw, 16'h0000};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [15:0] hw;
    int pick;
    rst = 1; dec_en = 0; instr_choose = 0; alu_go = 0; cin = 0;
    long_instr = 0; op1_data = 0; op2_data = 0; flags = 0; core_index = 0;
    #12;
    chk("reset_state", {dut_dec, result, result_flags, dest_out}, 128'd0);
    @(posedge clk); #1;
    rst = 0; chk_on = 1;

    do_dec(32'h0000_0053, 1, 4'b0000, 0);
    chk("adc_decode", {alu_en, alu_opcode, op1, op2, suffix, move_en}, {1'b1, 4'd1, 3'd2, 3'd3, 1'b1, 1'b0});
    do_dec(32'h8A00_1234, 0, 4'b0000, 0);
    chk("long_movh", {move_en, mov_type, op1, immediate, suffix, alu_en}, {1'b1, 3'b010, 3'd2, 16'h1234, 1'b1, 1'b0});
    do_dec(32'h0000_1444, 1, 4'b0000, 0);
    chk("cond_z_clear", {move_en, mov_type, op1, op2, suffix}, {1'b1, 3'b000, 3'd0, 3'd4, 1'b0});
    do_dec(32'h0000_1444, 1, 4'b1000, 0);
    chk("cond_z_set", suffix, 1'b1);
    do_dec(32'h7444_0000, 0, 4'b0000, 1);
    chk("cond_core1", suffix, 1'b0);
    do_dec(32'h7444_0000, 0, 4'b0000, 0);
    chk("cond_core0", suffix, 1'b1);

    do_dec(mk_alu(4'd0, 3'd5, 3'd6), 0, 0, 0);
    do_alu(32'hFFFF_FFFF, 32'h0000_0001, 0);
    chk("add_wrap", {result, result_flags, dest_out}, {32'h0, 4'b1001, 3'd5});
    do_dec(mk_alu(4'd2, 3'd1, 3'd2), 0, 0, 0);
    do_alu(32'h8000_0000, 32'h0000_0001, 0);
    chk("sub_overflow", {result, result_flags}, {32'h7FFF_FFFF, 4'b0100});
    do_dec(mk_alu(4'd14, 3'd7, 3'd0), 0, 0, 0);
    do_alu(32'd5, 32'd7, 0);
    chk("cmp_5_7", {result, result_flags, dest_out}, {32'd5, 4'b0011, 3'd7});
    do_dec(32'h0000_1444, 1, 0, 0);
    do_alu(32'h1234_5678, 32'h1, 0);
    chk("alu_hold_not_alu", {result, result_flags}, {32'd5, 4'b0011});

    do_dec(32'h0C05_0000, 0, 0, 0);
    chk("sys_interrupt", {interrupt, int_num, write_stack_params, alu_en, move_en}, {1'b1, 3'd5, 1'b0, 1'b0, 1'b0});
    do_dec(32'h0000_0DC3, 1, 0, 0);
    chk("sys_stack", {write_stack_params, stack_param_coding, stack_param_reg, interrupt}, {1'b1, 2'b11, 3'd3, 1'b0});
    long_instr = 32'h0000_0053; instr_choose = 1; dec_en = 0;
    step();
    chk("dec_hold", {write_stack_params, stack_param_coding, alu_en}, {1'b1, 2'b11, 1'b0});
    do_dec(32'h0F05_0000, 0, 0, 0);
    chk("sys_nop", {alu_en, mem_en, wren, move_en, interrupt, write_stack_params}, 6'd0);

    for (int i = 0; i < 3000; i++) begin
      dec_en = ($urandom_range(3) != 0);
      pick = $urandom_range(9);
      instr_choose = 1'($urandom_range(1));
      if (pick < 2) begin
        long_instr = {1'b1, 31'($urandom)};
      end else begin
        hw = 16'($urandom);
        hw[15] = 1'b0;
        if (pick < 6) hw[11:10] = 2'b00;
        long_instr = instr_choose ? {1'b0, 15'($urandom), hw} : {hw, 16'($urandom)};
      end
      flags = 4'($urandom); core_index = 2'($urandom);
      alu_go = 1'($urandom_range(1)); cin = 1'($urandom_range(1));
      op1_data = rand_word(); op2_data = rand_word();
      step();
      if (i == 1500) begin
        #2 rst = 1;
        #1 chk("async_reset", {dut_dec, result, result_flags, dest_out}, 128'd0);
        #4 rst = 0;
      end
    end

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
